// File: rtl/pll_reset_seq.sv
// Reset sequencer for the 16 MHz system PLL domain: synchronises and qualifies lock,
// holds reset for a fixed period, and re-asserts it on lock loss or soft-reset request.
module pll_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CW            = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    logic          sync_q;
    logic          locked_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    state_next;
    logic          loss_event;

    // pll_locked is asynchronous to clk; only locked_s is used past this point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values on the same edge, giving a true 2-stage chain.
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        loss_event = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (locked_s) state_next = STABLE;
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                // RUN: lock loss takes priority over a simultaneous soft reset.
                cnt_next = '0;
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end else if (soft_reset) begin
                    state_next = HOLD;
                end
            end
        endcase
    end

    // Reset outputs are loaded from the next state so they switch on the same edge as state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            sys_reset_n     <= 1'b0;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sys_reset_n <= (state_next == RUN);
            ready       <= (state_next == RUN);
            if (loss_event && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

endmodule
